// File: rtl/calc_display_writer.sv
// Binary-to-BCD result writer: sequential double-dabble conversion with a load/busy/done
// handshake, feeding a continuously scanned 4-digit active-low 7-segment display.
module calc_display_writer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] number,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   acc_q, acc_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   adj;
    logic [3:0]    digit;
    logic          blank;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                           : acc_q[gi*4 +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        step_d  = step_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (number > 32'd9999) begin
                        bcd_d   = 16'hFFFF;
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bin_d   = number[13:0];
                        acc_d   = 16'h0000;
                        step_d  = 4'd0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d  = {adj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                step_d = step_q + 4'd1;
                if (step_q == 4'd13) begin
                    bcd_d   = {adj[14:0], bin_q[13]};
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // A digit is blanked only when it and every more significant digit are zero
    always_comb begin
        digit = bcd_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd0: digit = bcd_q[3:0];
            2'd1: begin
                digit = bcd_q[7:4];
                blank = (bcd_q[15:4] == 12'h000);
            end
            2'd2: begin
                digit = bcd_q[11:8];
                blank = (bcd_q[15:8] == 8'h00);
            end
            default: begin
                digit = bcd_q[15:12];
                blank = (bcd_q[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        seg = 7'h7F;
        if (ovf_q) begin
            seg = 7'b0111111;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'h7F;
            endcase
        end
    end

    assign an       = ~(4'b0001 << idx_q);
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_calc_display_writer.sv
// Directed testbench for calc_display_writer with SCAN_DIV=4 and hand-computed expectations.
module tb_calc_display_writer;
    logic        clk;
    logic        rst_n;
    logic [31:0] number;
    logic        load;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    calc_display_writer #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .number   (number),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Starts at a negedge; load is presented for the next edge (edge k). Cycle c is the
    // cycle after edge k+c-1. An optional second load is pulsed during cycle inj_at.
    task automatic run_load(input logic [31:0] n, input int inj_at, input logic [31:0] inj_val,
                            output int busy_cnt, output int done_at, output int done_cnt);
        load   = 1'b1;
        number = n;
        @(negedge clk);
        load     = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == inj_at) begin
                load   = 1'b1;
                number = inj_val;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = 'x;
        for (int i = 0; i < 16; i++) begin
            case (an)
                4'b1110: s[0] = seg;
                4'b1101: s[1] = seg;
                4'b1011: s[2] = seg;
                4'b0111: s[3] = seg;
                default: ;
            endcase
            @(negedge clk);
        end
        check({tag, " dig0"}, {25'd0, s[0]}, {25'd0, e0});
        check({tag, " dig1"}, {25'd0, s[1]}, {25'd0, e1});
        check({tag, " dig2"}, {25'd0, s[2]}, {25'd0, e2});
        check({tag, " dig3"}, {25'd0, s[3]}, {25'd0, e3});
    endtask

    task automatic check_load(input string tag, input logic [31:0] n, input int exp_busy,
                              input int exp_done_at, input logic [15:0] exp_bcd,
                              input logic exp_ovf);
        int bc, da, dc;
        run_load(n, 0, 32'd0, bc, da, dc);
        check({tag, " busy_cycles"}, bc, exp_busy);
        check({tag, " done_at"}, da, exp_done_at);
        check({tag, " done_pulses"}, dc, 1);
        check({tag, " bcd"}, {16'd0, bcd}, {16'd0, exp_bcd});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        int bc, da, dc;
        logic [3:0] exp_an;
        rst_n  = 1'b0;
        load   = 1'b0;
        number = 32'd0;
        repeat (3) @(negedge clk);

        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst bcd", {16'd0, bcd}, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst an", {28'd0, an}, 32'hE);
        check("rst seg", {25'd0, seg}, {25'd0, SEG_0});

        // Scan rotation, each digit held exactly 4 cycles
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check($sformatf("scan an[%0d]", i), {28'd0, an}, {28'd0, exp_an});
            @(negedge clk);
        end

        check_load("load47", 32'd47, 14, 15, 16'h0047, 1'b0);
        check_display("disp47", SEG_7, SEG_4, SEG_BLANK, SEG_BLANK);

        check_load("load9999", 32'd9999, 14, 15, 16'h9999, 1'b0);
        check_display("disp9999", SEG_9, SEG_9, SEG_9, SEG_9);

        check_load("load0", 32'd0, 14, 15, 16'h0000, 1'b0);
        check_display("disp0", SEG_0, SEG_BLANK, SEG_BLANK, SEG_BLANK);

        check_load("load10000", 32'd10000, 0, 1, 16'hFFFF, 1'b1);
        check_display("disp10000", SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH);

        check_load("loadmax", 32'hFFFF_FFFF, 0, 1, 16'hFFFF, 1'b1);

        // Load during SHIFT must be ignored
        run_load(32'd1234, 5, 32'd5678, bc, da, dc);
        check("ign busy_cycles", bc, 14);
        check("ign done_at", da, 15);
        check("ign done_pulses", dc, 1);
        check("ign bcd", {16'd0, bcd}, 32'h1234);
        check_load("load5678", 32'd5678, 14, 15, 16'h5678, 1'b0);

        // Reset in the middle of a conversion
        check_load("load1234", 32'd1234, 14, 15, 16'h1234, 1'b0);
        load   = 1'b1;
        number = 32'd42;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("mid busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2 busy", {31'd0, busy}, 32'd0);
        check("rst2 bcd", {16'd0, bcd}, 32'd0);
        check("rst2 overflow", {31'd0, overflow}, 32'd0);
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dc++;
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check($sformatf("rst2 an[%0d]", i), {28'd0, an}, {28'd0, exp_an});
            @(negedge clk);
        end
        check("rst2 no_done", dc, 0);
        check_load("load42", 32'd42, 14, 15, 16'h0042, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/calc_display_writer.md
Name: calc_display_writer

Overview:
- Output-side counterpart of the keypad digit reader: takes a binary calculator result, converts it to four BCD digits, and drives a multiplexed 4-digit active-low 7-segment display.
- Sits between the calculator datapath and the board display pins.
- Conversion is sequential, using double-dabble, with a load/busy/done handshake.
- Display scanning runs continuously from the last completed result.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances (minimum 2).

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- number  input  32  unsigned binary value to display; sampled only on an accepted load.
- load  input  1  request a conversion; accepted only in IDLE.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  16  {d3,d2,d1,d0} BCD result; d0 is the units digit.
- overflow  output  1  last accepted number was > 9999.
- an  output  4  digit enables, active-low; an[0] is the units digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values: while rst_n=0 at a clock edge:
  - state goes to IDLE; busy=0, done=0, bcd=16'h0000, overflow=0.
  - Scan index goes to 0, scan counter to 0, an=4'b1110, seg shows '0' (7'b1000000).
  - Reset mid-conversion discards the conversion; no done pulse.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE, load=1 sampled at edge k:
  - number <= 9999: capture number[13:0] into a shift register, clear the 16-bit BCD accumulator and the step counter, go to SHIFT.
  - number > 9999: go to DONE, bcd <= 16'hFFFF, overflow <= 1.
- SHIFT, one double-dabble step per cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then shift {accumulator, binary} left by 1.
  - 14 steps occur at edges k+1 .. k+14.
  - At edge k+14: bcd <= accumulator, overflow <= 0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; the next edge returns to IDLE.
- Latency:
  - In-range: done is high during the cycle after edge k+14; busy is high during the cycles after edges k .. k+13.
  - Overflow: done is high during the cycle after edge k; busy never asserts.
- load in SHIFT or DONE is ignored, not queued. load held high in IDLE starts a new conversion on each return to IDLE.
- bcd and overflow hold their values between conversions. They are never partially updated; the accumulator is internal.
- Scan:
  - Counter runs 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the index advances 0→1→2→3→0.
  - an = ~(4'b0001 << index).
- Decode of the selected digit:
  - overflow=1: every digit shows a dash, 7'b0111111.
  - Else leading-zero blanking: digit i (i ≥ 1) is blank (7'h7F) if it and all higher digits are 0. Digit 0 is always shown.
  - Else standard 0-9 active-low patterns.
  - Nibble values 10-15 while overflow=0 display blank (defensive).
- Display uses the registered bcd/overflow, so the old value is shown during a conversion and switches on the done cycle.

Test Plan:
- Load 47 from IDLE → busy for 14 cycles, done exactly 15 cycles after the load edge, bcd=16'h0047, overflow=0; with SCAN_DIV=4, digit 0 shows '7', digit 1 shows '4', digits 2-3 blank.
- Load 9999, then load 0 → bcd=16'h9999, then 16'h0000; for 0 only digit 0 lit ('0'), digits 1-3 blank.
- Load 10000 (also 32'hFFFFFFFF) → done one cycle after the load edge, busy never high, bcd=16'hFFFF, overflow=1, all four digits show 7'b0111111.
- Load 1234, pulse load with 5678 at the 5th busy cycle → second load ignored, single done, bcd=16'h1234, a later load of 5678 gives 16'h5678.
- Load 1234 to completion, start load 42, assert rst_n=0 for one edge mid-SHIFT → busy=0, no done pulse, bcd=0, an=4'b1110, counter restarts; next load 42 completes normally.
- SCAN_DIV=4, no loads after reset → an cycles 1110,1101,1011,0111 with each value held exactly 4 cycles, then repeats.
